// File: rtl/imem_loader_if.sv
// Bus bundle between the UART-fed loader and its environment.
// It carries the load request, the received byte strobe, the instruction
// memory write port and the load status outputs.
interface imem_loader_if #(
   parameter int ADDR_WIDTH = 8
);
   logic                  start;
   logic                  rx_valid;
   logic [7:0]            rx_data;
   logic                  mem_we;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [7:0]            mem_wdata;
   logic                  busy;
   logic                  done;
   logic [1:0]            error;
   logic                  cpu_reset;

   // Environment side: issues requests and bytes, observes memory writes and status.
   modport master (
      output start, rx_valid, rx_data,
      input  mem_we, mem_addr, mem_wdata, busy, done, error, cpu_reset
   );

   // Loader side.
   modport slave (
      input  start, rx_valid, rx_data,
      output mem_we, mem_addr, mem_wdata, busy, done, error, cpu_reset
   );
endinterface

// File: rtl/imem_loader.sv
// Instruction memory loader.
// Frames a UART byte stream as LEN_LO, LEN_HI, payload, XOR checksum.
// Writes the payload to consecutive byte addresses starting at 0.
// Keeps the core in reset while a load is running or after a failed load.
module imem_loader #(
   parameter int ADDR_WIDTH     = 8,
   parameter int TIMEOUT_CYCLES = 1_000_000
) (
   input  logic           clk,
   input  logic           reset,
   imem_loader_if.slave   bus
);

   localparam int              MEM_BYTES    = 1 << ADDR_WIDTH;
   localparam logic [16:0]     MEM_BYTES_17 = 17'(MEM_BYTES);
   localparam int              TW           = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TW-1:0]   TMO_LAST     = TW'(TIMEOUT_CYCLES - 1);

   localparam logic [1:0] ERR_NONE = 2'd0;
   localparam logic [1:0] ERR_LEN  = 2'd1;
   localparam logic [1:0] ERR_CHK  = 2'd2;
   localparam logic [1:0] ERR_TMO  = 2'd3;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LEN_LO = 3'd1,
      S_LEN_HI = 3'd2,
      S_DATA   = 3'd3,
      S_CHECK  = 3'd4,
      S_DONE   = 3'd5,
      S_ERROR  = 3'd6
   } state_t;

   state_t                state_r, state_s;
   logic [15:0]           len_r, len_s;
   logic [15:0]           count_r, count_s;
   logic [7:0]            chk_r, chk_s;
   logic [TW-1:0]         tmo_r, tmo_s;
   logic                  mem_we_r, mem_we_s;
   logic [ADDR_WIDTH-1:0] mem_addr_r, mem_addr_s;
   logic [7:0]            mem_wdata_r, mem_wdata_s;
   logic [1:0]            error_r, error_s;
   logic                  busy_r, busy_s;
   logic                  done_r;
   logic                  cpu_reset_r;
   logic [15:0]           len_full_s;
   logic                  timeout_s;

   assign bus.mem_we    = mem_we_r;
   assign bus.mem_addr  = mem_addr_r;
   assign bus.mem_wdata = mem_wdata_r;
   assign bus.busy      = busy_r;
   assign bus.done      = done_r;
   assign bus.error     = error_r;
   assign bus.cpu_reset = cpu_reset_r;

   // Next-state, datapath updates and the timeout watchdog for the load sequence.
   always_comb begin
      state_s     = state_r;
      len_s       = len_r;
      count_s     = count_r;
      chk_s       = chk_r;
      tmo_s       = tmo_r;
      mem_we_s    = 1'b0;
      mem_addr_s  = mem_addr_r;
      mem_wdata_s = mem_wdata_r;
      error_s     = error_r;
      len_full_s  = {bus.rx_data, len_r[7:0]};
      timeout_s   = (tmo_r == TMO_LAST);

      case (state_r)
         S_IDLE, S_DONE, S_ERROR: begin
            // A byte arriving with start is dropped, not taken as LEN_LO.
            if (bus.start) begin
               state_s = S_LEN_LO;
               error_s = ERR_NONE;
               tmo_s   = '0;
            end else begin
               state_s = state_r;
            end
         end
         S_LEN_LO: begin
            if (bus.rx_valid) begin
               len_s   = {8'h00, bus.rx_data};
               tmo_s   = '0;
               state_s = S_LEN_HI;
            end else if (timeout_s) begin
               state_s = S_ERROR;
               error_s = ERR_TMO;
            end else begin
               tmo_s = tmo_r + TW'(1);
            end
         end
         S_LEN_HI: begin
            if (bus.rx_valid) begin
               len_s   = len_full_s;
               tmo_s   = '0;
               // Cleared for the empty frame too, whose checksum is the 8'h00 seed.
               count_s = 16'd0;
               chk_s   = 8'h00;
               if ({1'b0, len_full_s} > MEM_BYTES_17) begin
                  state_s = S_ERROR;
                  error_s = ERR_LEN;
               end else if (len_full_s == 16'd0) begin
                  state_s = S_CHECK;
               end else begin
                  state_s = S_DATA;
               end
            end else if (timeout_s) begin
               state_s = S_ERROR;
               error_s = ERR_TMO;
            end else begin
               tmo_s = tmo_r + TW'(1);
            end
         end
         S_DATA: begin
            if (bus.rx_valid) begin
               mem_we_s    = 1'b1;
               mem_addr_s  = count_r[ADDR_WIDTH-1:0];
               mem_wdata_s = bus.rx_data;
               chk_s       = chk_r ^ bus.rx_data;
               count_s     = count_r + 16'd1;
               tmo_s       = '0;
               if (count_r == (len_r - 16'd1)) begin
                  state_s = S_CHECK;
               end else begin
                  state_s = S_DATA;
               end
            end else if (timeout_s) begin
               state_s = S_ERROR;
               error_s = ERR_TMO;
            end else begin
               tmo_s = tmo_r + TW'(1);
            end
         end
         S_CHECK: begin
            if (bus.rx_valid) begin
               tmo_s = '0;
               if (bus.rx_data == chk_r) begin
                  state_s = S_DONE;
                  error_s = ERR_NONE;
               end else begin
                  state_s = S_ERROR;
                  error_s = ERR_CHK;
               end
            end else if (timeout_s) begin
               state_s = S_ERROR;
               error_s = ERR_TMO;
            end else begin
               tmo_s = tmo_r + TW'(1);
            end
         end
         default: begin
            state_s = S_IDLE;
         end
      endcase

      busy_s = (state_s == S_LEN_LO) || (state_s == S_LEN_HI) ||
               (state_s == S_DATA)   || (state_s == S_CHECK);
   end

   // State, datapath and output registers; status outputs follow the next state.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r     <= S_IDLE;
         len_r       <= 16'd0;
         count_r     <= 16'd0;
         chk_r       <= 8'h00;
         tmo_r       <= '0;
         mem_we_r    <= 1'b0;
         mem_addr_r  <= '0;
         mem_wdata_r <= 8'h00;
         error_r     <= ERR_NONE;
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
         cpu_reset_r <= 1'b0;
      end else begin
         state_r     <= state_s;
         len_r       <= len_s;
         count_r     <= count_s;
         chk_r       <= chk_s;
         tmo_r       <= tmo_s;
         mem_we_r    <= mem_we_s;
         mem_addr_r  <= mem_addr_s;
         mem_wdata_r <= mem_wdata_s;
         error_r     <= error_s;
         busy_r      <= busy_s;
         done_r      <= (state_s == S_DONE);
         cpu_reset_r <= busy_s || (state_s == S_ERROR);
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// Testbench for imem_loader (ADDR_WIDTH=4, TIMEOUT_CYCLES=16).
// A frame-level reference model queues the expected memory writes.
// A monitor process pops and compares them on every write strobe.
module tb_imem_loader;

   localparam int AW        = 4;
   localparam int TMO       = 16;
   localparam int MEM_BYTES = 1 << AW;

   typedef logic [7:0] byte_q_t[$];

   logic clk;
   logic reset;
   int   checks;
   int   errors;
   logic [15:0] wq[$];

   imem_loader_if #(.ADDR_WIDTH(AW)) bus ();

   imem_loader #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TMO)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Scoreboard monitor: every write strobe must match the next expected write.
   always @(negedge clk) begin
      logic [15:0] got;
      logic [15:0] exp;
      if (bus.mem_we === 1'b1) begin
         checks++;
         got = {8'(bus.mem_addr), bus.mem_wdata};
         if (wq.size() == 0) begin
            errors++;
            $display("FAIL write_unexpected: got addr/data=%04h, expected no write", got);
         end else begin
            exp = wq.pop_front();
            if (got !== exp) begin
               errors++;
               $display("FAIL write_data: got addr/data=%04h expected=%04h", got, exp);
            end
         end
      end
   end

   // Global bound so a stuck run still terminates.
   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      bus.rx_valid = 1'b1;
      bus.rx_data  = b;
      tick();
      bus.rx_valid = 1'b0;
   endtask

   task automatic do_start(input bit collide);
      bus.start    = 1'b1;
      bus.rx_valid = collide;
      bus.rx_data  = 8'h05;
      tick();
      bus.start    = 1'b0;
      bus.rx_valid = 1'b0;
      check("busy_after_start", {31'd0, bus.busy}, 32'd1);
      check("cpu_reset_after_start", {31'd0, bus.cpu_reset}, 32'd1);
   endtask

   task automatic check_status(input bit e_done, input logic [1:0] e_err,
                               input bit e_busy, input bit e_cpu);
      check("done", {31'd0, bus.done}, {31'd0, e_done});
      check("error", {30'd0, bus.error}, {30'd0, e_err});
      check("busy", {31'd0, bus.busy}, {31'd0, e_busy});
      check("cpu_reset", {31'd0, bus.cpu_reset}, {31'd0, e_cpu});
      check("writes_drained", wq.size(), 32'd0);
   endtask

   // Send a complete frame (or just its two length bytes) and check the outcome
   // the frame rules predict. Random idle gaps carry stray start pulses.
   task automatic send_frame(input byte_q_t fr, input int gap_max, input bit collide);
      int         len;
      logic [7:0] x;
      len = {fr[1], fr[0]};
      if (len <= MEM_BYTES) begin
         for (int i = 0; i < len && i + 2 < fr.size(); i++) begin
            wq.push_back({8'(i), fr[i+2]});
         end
      end
      do_start(collide);
      for (int i = 0; i < fr.size(); i++) begin
         if (i > 0) begin
            for (int g = $urandom_range(0, gap_max); g > 0; g--) begin
               bus.start = ($urandom_range(0, 3) == 0);
               tick();
               bus.start = 1'b0;
            end
         end
         send_byte(fr[i]);
      end
      if (len > MEM_BYTES) begin
         check_status(1'b0, 2'd1, 1'b0, 1'b1);
      end else begin
         x = 8'h00;
         for (int i = 0; i < len; i++) x = x ^ fr[i+2];
         if (fr[len+2] == x) check_status(1'b1, 2'd0, 1'b0, 1'b0);
         else                check_status(1'b0, 2'd2, 1'b0, 1'b1);
      end
   endtask

   initial begin
      byte_q_t     fr;
      logic [15:0] l16;
      logic [7:0]  x;
      int          r;
      checks       = 0;
      errors       = 0;
      reset        = 1'b1;
      bus.start    = 1'b0;
      bus.rx_valid = 1'b1;
      bus.rx_data  = 8'hA5;
      repeat (3) tick();
      bus.rx_valid = 1'b0;
      check("reset_mem_we", {31'd0, bus.mem_we}, 32'd0);
      check("reset_mem_addr", {28'd0, bus.mem_addr}, 32'd0);
      check("reset_mem_wdata", {24'd0, bus.mem_wdata}, 32'd0);
      check_status(1'b0, 2'd0, 1'b0, 1'b0);
      reset = 1'b0;
      tick();

      // Normal load from the reference vector.
      fr = '{8'h04, 8'h00, 8'h03, 8'hA3, 8'hC4, 8'hFF, 8'h9B};
      send_frame(fr, 0, 1'b0);

      // Full depth, back-to-back payload.
      fr = '{8'h10, 8'h00};
      x  = 8'h00;
      for (int i = 0; i < 16; i++) begin
         fr.push_back(8'($urandom));
         x = x ^ fr[i+2];
      end
      fr.push_back(x);
      send_frame(fr, 0, 1'b0);

      // One byte too long.
      fr = '{8'h11, 8'h00};
      send_frame(fr, 0, 1'b0);

      // Bad checksum, then recovery with a good frame.
      fr = '{8'h02, 8'h00, 8'h11, 8'h22, 8'h00};
      send_frame(fr, 1, 1'b0);
      fr = '{8'h02, 8'h00, 8'h11, 8'h22, 8'h33};
      send_frame(fr, 1, 1'b0);

      // Empty frame.
      fr = '{8'h00, 8'h00, 8'h00};
      send_frame(fr, 0, 1'b0);

      // Timeout: error exactly 16 cycles after the last accepted byte.
      do_start(1'b0);
      send_byte(8'h02);
      repeat (15) tick();
      check("tmo_not_yet_error", {30'd0, bus.error}, 32'd0);
      check("tmo_not_yet_busy", {31'd0, bus.busy}, 32'd1);
      tick();
      check_status(1'b0, 2'd3, 1'b0, 1'b1);

      // A byte on the final cycle wins over the timeout.
      do_start(1'b0);
      send_byte(8'h02);
      repeat (15) tick();
      wq.push_back({8'd0, 8'h11});
      wq.push_back({8'd1, 8'h22});
      send_byte(8'h00);
      check("tmo_last_cycle_error", {30'd0, bus.error}, 32'd0);
      check("tmo_last_cycle_busy", {31'd0, bus.busy}, 32'd1);
      send_byte(8'h11);
      send_byte(8'h22);
      send_byte(8'h33);
      check_status(1'b1, 2'd0, 1'b0, 1'b0);

      // start and rx_valid together: the byte must not become LEN_LO.
      fr = '{8'h02, 8'h00, 8'h11, 8'h22, 8'h33};
      send_frame(fr, 0, 1'b1);

      // Reset in the middle of DATA, with a byte arriving in the reset cycle.
      do_start(1'b0);
      send_byte(8'h04);
      send_byte(8'h00);
      wq.push_back({8'd0, 8'hAA});
      wq.push_back({8'd1, 8'hBB});
      send_byte(8'hAA);
      send_byte(8'hBB);
      reset        = 1'b1;
      bus.rx_valid = 1'b1;
      bus.rx_data  = 8'hCC;
      tick();
      bus.rx_valid = 1'b0;
      reset        = 1'b0;
      check("midreset_mem_we", {31'd0, bus.mem_we}, 32'd0);
      check("midreset_mem_addr", {28'd0, bus.mem_addr}, 32'd0);
      check("midreset_mem_wdata", {24'd0, bus.mem_wdata}, 32'd0);
      check_status(1'b0, 2'd0, 1'b0, 1'b0);
      // Back in IDLE: a byte without start is ignored.
      send_byte(8'h77);
      tick();
      check_status(1'b0, 2'd0, 1'b0, 1'b0);

      // Randomized frames against the frame-level model.
      for (int n = 0; n < 30; n++) begin
         r = $urandom_range(0, 9);
         if (r == 0) begin
            l16 = 16'($urandom_range(MEM_BYTES + 1, 700));
            fr  = '{l16[7:0], l16[15:8]};
         end else begin
            l16 = 16'($urandom_range(0, MEM_BYTES));
            fr  = '{l16[7:0], l16[15:8]};
            x   = 8'h00;
            for (int i = 0; i < int'(l16); i++) begin
               fr.push_back(8'($urandom));
               x = x ^ fr[i+2];
            end
            if (r == 1) x = x ^ 8'($urandom_range(1, 255));
            fr.push_back(x);
         end
         send_frame(fr, $urandom_range(0, 3), ($urandom_range(0, 4) == 0));
      end

      tick();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/imem_loader.md
# imem_loader

Write-side counterpart to the byte-addressed instruction memory. Takes a byte stream from the UART receiver, frames it as length + payload + checksum, and writes each payload byte into instruction memory at consecutive byte addresses from 0. Holds the core in reset while a load is in progress or has failed, and releases it once a load completes cleanly.

## Interface

**Parameters**
- `ADDR_WIDTH`, default 8: instruction memory byte-address width. Capacity `MEM_BYTES = 2**ADDR_WIDTH`. Legal range 2..16.
- `TIMEOUT_CYCLES`, default 1_000_000: maximum number of idle cycles allowed between accepted bytes during a load.

**Ports**
- `clk` input, 1: single clock.
- `reset` input, 1: synchronous, active-high.
- `start` input, 1: single-cycle request to begin a load.
- `rx_valid` input, 1: single-cycle strobe, one received byte. There is no backpressure, so every strobe must be consumed in a receiving state.
- `rx_data` input, 8: received byte, qualified by `rx_valid`.
- `mem_we` output, 1: byte write enable to instruction memory.
- `mem_addr` output, `ADDR_WIDTH`: byte address.
- `mem_wdata` output, 8: byte to write.
- `busy` output, 1: a load is in progress.
- `done` output, 1: the last load succeeded.
- `error` output, 2: error code. 0 = none, 1 = length too large, 2 = checksum mismatch, 3 = timeout.
- `cpu_reset` output, 1: hold the core in reset.

## Operation

**Frame format**
- Byte sequence: `LEN[7:0]`, `LEN[15:8]`, then `LEN` payload bytes, then `CHK`.
- `CHK` is the XOR of all payload bytes, with a seed of 8'h00.

**States**
- `IDLE`
  - `start` → `LEN_LO`.
  - `rx_valid` is ignored.
- `LEN_LO`
  - Accepting a byte latches the low length byte, then → `LEN_HI`.
- `LEN_HI`
  - Accepting a byte latches the high length byte and forms the 16-bit `len`.
  - `len > MEM_BYTES` (compared at 17 bits) → `ERROR` with code 1.
  - `len == 0` → `CHECK`.
  - Otherwise → `DATA`, with the byte count cleared and the checksum cleared.
- `DATA`
  - Each accepted byte is written at `mem_addr = count[ADDR_WIDTH-1:0]` and XORed into the checksum; count is then incremented.
  - When `count == len-1` on acceptance → `CHECK`.
  - `len == MEM_BYTES` is legal; the last write goes to address `MEM_BYTES-1`.
- `CHECK`
  - The accepted byte is compared with the running checksum.
  - Equal → `DONE`.
  - Not equal → `ERROR` with code 2.
- `DONE`
  - `done` = 1.
  - `start` → `LEN_LO`; this clears `done` and `error`.
- `ERROR`
  - `error` holds its code.
  - `start` → `LEN_LO`; this clears `error`.

**Timeout**
- The counter runs in `LEN_LO`, `LEN_HI`, `DATA` and `CHECK`.
- It is cleared on entry to `LEN_LO` and on every accepted byte.
- When it reaches `TIMEOUT_CYCLES-1` with no byte accepted → `ERROR` with code 3.
- If a byte is accepted in that same cycle, the byte wins.

**Outputs**
- `busy` = 1 in `LEN_LO`, `LEN_HI`, `DATA`, `CHECK`.
- `cpu_reset` = `busy` OR (state == `ERROR`).
- `start` is ignored while `busy`.
- Payload already written before an error is not rolled back.

## Timing

**Reset values**
- State = `IDLE`.
- `mem_we`, `mem_addr`, `mem_wdata`, `busy`, `done`, `error` and `cpu_reset` are all 0.
- Length, count, checksum and timeout counter are all 0.

**Latency**
- `start` sampled at edge N → `busy` = 1 and `cpu_reset` = 1 after edge N.
- A byte accepted at edge N in `DATA` → `mem_we` = 1 for exactly one cycle after edge N, with `mem_addr` and `mem_wdata` registered at the same edge.
- Consecutive `rx_valid` on back-to-back cycles must be supported. This gives one write per cycle with no byte lost.
- `CHK` accepted at edge N → `done` (or `error`) valid after edge N, and `busy` and `cpu_reset` (on success) drop at the same edge.

**Edge cases**
- `start` and `rx_valid` asserted together in `IDLE`, `DONE` or `ERROR`: the byte is dropped and is not treated as `LEN_LO`.
- `reset` mid-load: the next state is `IDLE` with all outputs at reset values; no write is issued in the reset cycle.
- `mem_we` is never asserted outside the cycle that follows a `DATA` acceptance.

## Test plan

- **Normal load:** `ADDR_WIDTH=4`, `start`, then bytes 04,00,03,A3,C4,FF,9B → writes addr0..3 = 03,A3,C4,FF on consecutive write strobes. Checksum 03^A3^C4^FF = 9B, so `done` = 1, `error` = 0, `cpu_reset` = 0.
- **Full depth with back-to-back strobes:** `len` = 16 (bytes 10,00), 16 payload bytes on consecutive cycles, then the correct `CHK` → 16 writes to addr 0..15 with no gaps and `done` = 1. Repeat with `len` = 17 (bytes 11,00) → `error` = 1 right after the second length byte, no writes, `cpu_reset` = 1.
- **Bad checksum:** `len` = 2, payload 11,22, `CHK` = 00 → 2 writes, then `error` = 2, `cpu_reset` = 1. A following `start` plus a valid frame → `done` = 1 and `error` = 0.
- **Timeout:** `TIMEOUT_CYCLES=16`, `start`, byte 02, then silence → `error` = 3 exactly 16 cycles after the last accepted byte. Separately, a byte arriving on the final cycle → no error.
- **Empty frame:** `len` = 0 (bytes 00,00), `CHK` = 00 → no writes and `done` = 1.
- **Reset and collisions:** `reset` mid-`DATA` → all outputs 0 on the next cycle and state `IDLE`. `start` with simultaneous `rx_valid` in `IDLE` → that byte is not taken as `LEN_LO`.
